// File: rtl/seg_display_ctrl.sv
// Multiplexed seven-segment driver. A sequential double-dabble engine converts a captured
// binary value to BCD, and a registered scanner drives the digits with blanking, DP, blink and overflow.

module seg_digit_dec (
  input  logic [3:0] nib,
  input  logic       blank,
  input  logic       ovf,
  output logic [6:0] seg   // active-high {A,B,C,D,E,F,G}
);
  always_comb begin
    seg = 7'b0000000;
    if (ovf) seg = 7'b0000001;
    else if (!blank) begin
      case (nib)
        4'd0:    seg = 7'b1111110;
        4'd1:    seg = 7'b0110000;
        4'd2:    seg = 7'b1101101;
        4'd3:    seg = 7'b1111001;
        4'd4:    seg = 7'b0110011;
        4'd5:    seg = 7'b1011011;
        4'd6:    seg = 7'b1011111;
        4'd7:    seg = 7'b1110000;
        4'd8:    seg = 7'b1111111;
        4'd9:    seg = 7'b1111011;
        default: seg = 7'b0000000;
      endcase
    end
  end
endmodule

module seg_display_ctrl #(
  parameter int NUM_DIGITS     = 8,
  parameter int BIN_WIDTH      = 32,
  parameter int SCAN_DIV       = 1024,
  parameter int BLINK_BITS     = 24,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit COM_ACTIVE_LOW = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [BIN_WIDTH-1:0]  VALUE,
  input  logic                  LOAD,
  input  logic                  BLANK_LZ,
  input  logic                  BLINK_EN,
  input  logic [NUM_DIGITS-1:0] DP_MASK,
  output logic                  BUSY,
  output logic                  OVERFLOW,
  output logic [NUM_DIGITS-1:0] Com,
  output logic [6:0]            SEG,
  output logic                  DP
);
  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(BIN_WIDTH - 1);
  localparam logic [PW-1:0] PS_LAST    = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] COM_OFF = {NUM_DIGITS{COM_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] ONE_HOT = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t                       state, state_nx;
  logic [BIN_WIDTH-1:0]         bin_q, bin_nx;
  logic [NUM_DIGITS-1:0][3:0]   bcd_q, bcd_nx, bcd_adj;
  logic                         ovf_w_q, ovf_w_nx;
  logic [CW-1:0]                cnt_q, cnt_nx;
  logic [NUM_DIGITS-1:0][3:0]   disp_q, disp_nx;
  logic                         ovf_q, ovf_nx;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      ovf_w_q <= 1'b0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      bin_q   <= bin_nx;
      bcd_q   <= bcd_nx;
      ovf_w_q <= ovf_w_nx;
      cnt_q   <= cnt_nx;
      disp_q  <= disp_nx;
      ovf_q   <= ovf_nx;
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd_q[i] >= 4'd5) bcd_adj[i] = bcd_q[i] + 4'd3;
  end

  always_comb begin
    state_nx = state;
    bin_nx   = bin_q;
    bcd_nx   = bcd_q;
    ovf_w_nx = ovf_w_q;
    cnt_nx   = cnt_q;
    disp_nx  = disp_q;
    ovf_nx   = ovf_q;
    case (state)
      S_IDLE: if (LOAD) begin
        bin_nx   = VALUE;
        bcd_nx   = '0;
        ovf_w_nx = 1'b0;
        cnt_nx   = '0;
        state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        // a set MSB after adjustment is a carry out of the top digit: value too wide
        if (bcd_adj[NUM_DIGITS-1][3]) ovf_w_nx = 1'b1;
        {bcd_nx, bin_nx} = {bcd_adj, bin_q} << 1;
        cnt_nx = cnt_q + 1'b1;
        if (cnt_q == SHIFT_LAST) state_nx = S_COMMIT;
      end
      S_COMMIT: begin
        disp_nx  = bcd_q;
        ovf_nx   = ovf_w_q;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign BUSY     = (state != S_IDLE);
  assign OVERFLOW = ovf_q;

  logic [PW-1:0]         ps_q;
  logic [IW-1:0]         idx_q;
  logic [BLINK_BITS:0]   blk_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ps_q  <= '0;
      idx_q <= '0;
      blk_q <= '0;
    end else begin
      blk_q <= blk_q + 1'b1;
      if (ps_q == PS_LAST) begin
        ps_q  <= '0;
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        ps_q <= ps_q + 1'b1;
      end
    end
  end

  // digit i>0 blanks when it and everything above it is zero
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  lz_run;
  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_run      = lz_run | (|disp_q[i]);
      lz_blank[i] = BLANK_LZ & ~lz_run;
    end
  end

  logic [NUM_DIGITS-1:0][6:0] seg_dig;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg_digit_dec u_dec (
      .nib   (disp_q[g]),
      .blank (lz_blank[g]),
      .ovf   (ovf_q),
      .seg   (seg_dig[g])
    );
  end

  logic com_on;
  assign com_on = ~(BLINK_EN & blk_q[BLINK_BITS]);

  // Com and SEG/DP share one register stage off idx_q so they switch together
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Com <= COM_OFF;
      SEG <= SEG_OFF;
      DP  <= SEG_ACTIVE_LOW;
    end else begin
      Com <= com_on ? (COM_OFF ^ (ONE_HOT << idx_q)) : COM_OFF;
      SEG <= seg_dig[idx_q] ^ SEG_OFF;
      DP  <= (DP_MASK[idx_q] & ~ovf_q) ^ SEG_ACTIVE_LOW;
    end
  end
endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench: loaded values are queued and checked against the scanned display when BUSY drops.
module tb_seg_display_ctrl;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic [31:0] val8, val4;
  logic        load8, load4, blz, blink_en;
  logic [7:0]  dp8;
  logic [3:0]  dp4;
  logic        busy8, ovf8, busy4, ovf4, dpo8, dpo4;
  logic [7:0]  com8;
  logic [3:0]  com4;
  logic [6:0]  seg8, seg4;

  seg_display_ctrl #(.NUM_DIGITS(8), .BIN_WIDTH(32), .SCAN_DIV(4), .BLINK_BITS(6),
                     .SEG_ACTIVE_LOW(1'b1), .COM_ACTIVE_LOW(1'b1)) dut8 (
    .CLK(CLK), .RST(RST), .VALUE(val8), .LOAD(load8), .BLANK_LZ(blz), .BLINK_EN(blink_en),
    .DP_MASK(dp8), .BUSY(busy8), .OVERFLOW(ovf8), .Com(com8), .SEG(seg8), .DP(dpo8));

  seg_display_ctrl #(.NUM_DIGITS(4), .BIN_WIDTH(32), .SCAN_DIV(4), .BLINK_BITS(6),
                     .SEG_ACTIVE_LOW(1'b1), .COM_ACTIVE_LOW(1'b1)) dut4 (
    .CLK(CLK), .RST(RST), .VALUE(val4), .LOAD(load4), .BLANK_LZ(blz), .BLINK_EN(1'b0),
    .DP_MASK(dp4), .BUSY(busy4), .OVERFLOW(ovf4), .Com(com4), .SEG(seg4), .DP(dpo4));

  int checks = 0;
  int passes = 0;
  bit use4 = 1'b0;
  longint sbq[$];

  function automatic longint pow10(input int k);
    longint p = 1;
    for (int j = 0; j < k; j++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'b1111110;  1: return 7'b0110000;  2: return 7'b1101101;
      3: return 7'b1111001;  4: return 7'b0110011;  5: return 7'b1011011;
      6: return 7'b1011111;  7: return 7'b1110000;  8: return 7'b1111111;
      9: return 7'b1111011;  default: return 7'b0000000;
    endcase
  endfunction

  // active-low expected SEG for digit i
  function automatic logic [6:0] exp_seg(input longint v, input int i, input int n, input bit bl);
    if (v >= pow10(n)) return ~7'b0000001;
    if (bl && i > 0 && v < pow10(i)) return 7'h7F;
    return ~digit_seg(int'((v / pow10(i)) % 10));
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic strobe(input longint v);
    if (use4) begin val4 = v[31:0]; load4 = 1'b1; end
    else      begin val8 = v[31:0]; load8 = 1'b1; end
    tick();
    load4 = 1'b0; load8 = 1'b0;
  endtask

  task automatic do_load(input longint v);
    strobe(v);
    sbq.push_back(v);
  endtask

  task automatic check_display(input string name, input longint v);
    logic [7:0] com;
    logic [6:0] cap [8];
    bit         seen [8];
    int         n = use4 ? 4 : 8;
    int         bad = 0;
    int         idx;
    logic       o;
    bit         exp_o;
    o = use4 ? ovf4 : ovf8;
    exp_o = (v >= pow10(n));
    checks++;
    if (o !== exp_o) $display("FAIL %s overflow got=%b exp=%b", name, o, exp_o);
    else passes++;
    for (int k = 0; k < 8; k++) begin seen[k] = 1'b0; cap[k] = 7'h00; end
    for (int c = 0; c < 2 * n * 4 + 4; c++) begin
      com = use4 ? {4'hF, com4} : com8;
      if ($countones(~com) == 1) begin
        idx = 0;
        for (int k = 0; k < 8; k++) if (!com[k]) idx = k;
        if (idx >= n) bad++;
        cap[idx]  = use4 ? seg4 : seg8;
        seen[idx] = 1'b1;
      end else begin
        bad++;
      end
      tick();
    end
    checks++;
    if (bad != 0) $display("FAIL %s com_onehot bad_cycles=%0d exp=0", name, bad);
    else passes++;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (!seen[i] || cap[i] !== exp_seg(v, i, n, blz))
        $display("FAIL %s digit%0d seg got=%b seen=%0d exp=%b", name, i, cap[i], seen[i], exp_seg(v, i, n, blz));
      else passes++;
    end
  endtask

  task automatic wait_done(input string name, input int exp_hi);
    int     hi = 0;
    logic   b;
    longint v;
    b = use4 ? busy4 : busy8;
    while (b === 1'b1 && hi < 200) begin
      hi++;
      tick();
      b = use4 ? busy4 : busy8;
    end
    checks++;
    if (hi != exp_hi) $display("FAIL %s busy_cycles got=%0d exp=%0d", name, hi, exp_hi);
    else passes++;
    if (sbq.size() == 0) begin
      checks++;
      $display("FAIL %s scoreboard_empty got=0 exp=1", name);
    end else begin
      v = sbq.pop_front();
      check_display(name, v);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy8, ovf8, com8, seg8, dpo8} !== {1'b0, 1'b0, 8'hFF, 7'h7F, 1'b1})
      $display("FAIL reset8 got=%b exp=%b", {busy8, ovf8, com8, seg8, dpo8}, {1'b0, 1'b0, 8'hFF, 7'h7F, 1'b1});
    else passes++;
    checks++;
    if ({busy4, ovf4, com4, seg4, dpo4} !== {1'b0, 1'b0, 4'hF, 7'h7F, 1'b1})
      $display("FAIL reset4 got=%b exp=%b", {busy4, ovf4, com4, seg4, dpo4}, {1'b0, 1'b0, 4'hF, 7'h7F, 1'b1});
    else passes++;
    RST = 1'b0;
    tick();
    use4 = 1'b0;
    check_display("reset_zero", 0);
  endtask

  task automatic test_convert();
    use4 = 1'b0; blz = 1'b0;
    do_load(12345678);
    wait_done("convert", 33);
  endtask

  task automatic test_lz();
    use4 = 1'b0; blz = 1'b1;
    do_load(0);
    wait_done("lz_zero", 33);
    do_load(507);
    wait_done("lz_507", 33);
    blz = 1'b0;
  endtask

  task automatic test_overflow();
    use4 = 1'b1;
    do_load(9999);
    wait_done("ovf_9999", 33);
    do_load(10000);
    wait_done("ovf_10000", 33);
    use4 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int extra = 0;
    use4 = 1'b0;
    do_load(42);
    repeat (4) tick();
    strobe(99);
    wait_done("b2b", 28);
    for (int c = 0; c < 40; c++) begin
      if (busy8 !== 1'b0) extra++;
      tick();
    end
    checks++;
    if (extra != 0 || sbq.size() != 0) $display("FAIL b2b second_busy got=%0d exp=0", extra);
    else passes++;
  endtask

  task automatic test_reset_mid();
    use4 = 1'b0;
    strobe(777);
    repeat (9) tick();
    RST = 1'b1;
    #1;
    checks++;
    if ({busy8, com8, seg8, dpo8} !== {1'b0, 8'hFF, 7'h7F, 1'b1})
      $display("FAIL reset_mid got=%b exp=%b", {busy8, com8, seg8, dpo8}, {1'b0, 8'hFF, 7'h7F, 1'b1});
    else passes++;
    tick(); tick();
    RST = 1'b0;
    tick();
    check_display("reset_mid_zero", 0);
    do_load(777);
    wait_done("reset_mid_777", 33);
  endtask

  task automatic test_scan_blink();
    int         runs [$];
    int         run = 0;
    int         bad_hold = 0, bad_dp = 0;
    logic [7:0] prev;
    bit         poff, off;
    dp8 = 8'h04; blink_en = 1'b0;
    tick(); tick();
    prev = com8;
    for (int c = 0; c < 80; c++) begin
      tick();
      if ((dpo8 === 1'b0) != (com8 === 8'hFB)) bad_dp++;
      if (com8 === prev) run++;
      else begin runs.push_back(run + 1); run = 0; prev = com8; end
    end
    for (int k = 1; k < runs.size(); k++) if (runs[k] != 4) bad_hold++;
    checks++;
    if (bad_hold != 0 || runs.size() < 10) $display("FAIL scan_hold bad_runs=%0d runs=%0d exp_len=4", bad_hold, runs.size());
    else passes++;
    checks++;
    if (bad_dp != 0) $display("FAIL dp_mask bad_cycles=%0d exp=0", bad_dp);
    else passes++;
    runs.delete();
    blink_en = 1'b1;
    tick();
    poff = (com8 === 8'hFF);
    run = 1;
    for (int c = 0; c < 450; c++) begin
      tick();
      off = (com8 === 8'hFF);
      if (off == poff) run++;
      else begin runs.push_back(run); run = 1; poff = off; end
    end
    checks++;
    if (runs.size() < 5) $display("FAIL blink_transitions got=%0d exp>=5", runs.size());
    else passes++;
    for (int k = 1; k < 5 && k < runs.size(); k++) begin
      checks++;
      if (runs[k] != 64) $display("FAIL blink_window%0d len got=%0d exp=64", k, runs[k]);
      else passes++;
    end
    blink_en = 1'b0; dp8 = 8'h00;
  endtask

  initial begin
    RST = 1'b1; val8 = '0; val4 = '0; load8 = 1'b0; load4 = 1'b0;
    blz = 1'b0; blink_en = 1'b0; dp8 = '0; dp4 = '0;
    test_reset();
    test_convert();
    test_lz();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_scan_blink();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
